seq_detect_param: RTL and testbench

Parametrised serial pattern detector, the next generation of the team's fixed "111" Mealy detector. It adds a run-time programmable pattern and length, overlap/non-overlap mode, a sample-enable qualifier and a saturating match counter. It sits on a serial bit stream next to the other assignment FSMs. It flags each completed pattern occurrence with a one-cycle registered pulse.

---
 rtl/seq_detect_param.sv | 149 ++++++++++++++
 tb/tb_seq_detect_param.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with a run-time programmable pattern and length,
// overlap/non-overlap modes, a sample enable and a saturating match counter.
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             ovl,
    input  logic             en,
    input  logic             x_inp,
    output logic             y_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]   hcnt_q, hcnt_d;
    logic               y_q, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               cfg_ok_s;
    logic [PAT_W-1:0]   h_next_s;
    logic [LEN_W-1:0]   c_next_s;
    logic               match_s;

    // Only the low len bits take part in the comparison.
    function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [PAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(len)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    assign cfg_ok_s = (pat_len != '0) && (pat_len <= PAT_W_L);
    assign h_next_s = {hist_q[PAT_W-2:0], x_inp};
    assign c_next_s = (hcnt_q >= PAT_W_L) ? PAT_W_L : (hcnt_q + LEN_W'(1));
    assign match_s  = (c_next_s >= len_q) &&
                      (((h_next_s ^ pat_q) & len_mask(len_q)) == '0);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        hcnt_d  = hcnt_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        y_d     = 1'b0;

        if (cfg_load) begin
            // A (re)load always restarts detection from an empty history.
            pat_d  = pat;
            len_d  = pat_len;
            ovl_d  = ovl;
            hist_d = '0;
            hcnt_d = '0;
            cnt_d  = '0;
            if (cfg_ok_s) begin
                state_d = ST_RUN;
                err_d   = 1'b0;
            end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (en) begin
                        hist_d = h_next_s;
                        y_d    = match_s;
                        if (match_s && !ovl_q) begin
                            hcnt_d = '0;
                        end else begin
                            hcnt_d = c_next_s;
                        end
                        if (match_s && (cnt_q != {CNT_W{1'b1}})) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end else begin
                        hist_d = hist_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            hcnt_q  <= '0;
            y_q     <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            hcnt_q  <= hcnt_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign y_out     = y_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: one default instance plus a 2-bit-counter
// instance driven in parallel for the saturation case.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] pat = 8'd0;
    logic [3:0] pat_len = 4'd0;
    logic       ovl = 1'b0;
    logic       en = 1'b0;
    logic       x_inp = 1'b0;
    logic       y_out, cfg_err, y_sat, err_sat;
    logic [7:0] match_cnt;
    logic [1:0] cnt_sat;

    int n_checks = 0;
    int n_errors = 0;

    seq_detect_param #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len),
        .ovl(ovl), .en(en), .x_inp(x_inp), .y_out(y_out), .match_cnt(match_cnt),
        .cfg_err(cfg_err)
    );

    seq_detect_param #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len),
        .ovl(ovl), .en(en), .x_inp(x_inp), .y_out(y_sat), .match_cnt(cnt_sat),
        .cfg_err(err_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_load = 1'b1;
        pat      = p;
        pat_len  = l;
        ovl      = o;
        en       = 1'b0;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic step(input logic x, input logic e, input logic exp_y, input string tag);
        x_inp = x;
        en    = e;
        tick();
        check(tag, {31'd0, y_out}, {31'd0, exp_y});
    endtask

    // Feeds n bits MSB first, checking y_out against the hand-derived pulse vector.
    task automatic run_stream(input logic [31:0] bits, input logic [31:0] exp_y,
                              input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, exp_y[i], tag);
        end
    endtask

    initial begin
        #2;
        check("rst_y", {31'd0, y_out}, 32'd0);
        check("rst_cnt", {24'd0, match_cnt}, 32'd0);
        check("rst_err", {31'd0, cfg_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // No detection before any configuration
        step(1'b1, 1'b1, 1'b0, "idle_y");
        step(1'b1, 1'b1, 1'b0, "idle_y");

        // 111 non-overlap on the reference stream
        load_cfg(8'b0000_0111, 4'd3, 1'b0);
        check("cfg_y", {31'd0, y_out}, 32'd0);
        run_stream(32'b0111011111100111111111, 32'b0001000100100001001001, 22, "nov_y");
        check("nov_cnt", {24'd0, match_cnt}, 32'd6);

        // Same stream, overlapping
        load_cfg(8'b0000_0111, 4'd3, 1'b1);
        check("reload_cnt", {24'd0, match_cnt}, 32'd0);
        run_stream(32'b0111011111100111111111, 32'b0001000111100001111111, 22, "ovl_y");
        check("ovl_cnt", {24'd0, match_cnt}, 32'd12);

        // 1011 overlap and non-overlap
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        run_stream(32'b1011011, 32'b0001001, 7, "p1011o_y");
        check("p1011o_cnt", {24'd0, match_cnt}, 32'd2);
        load_cfg(8'b0000_1011, 4'd4, 1'b0);
        run_stream(32'b1011011, 32'b0001000, 7, "p1011n_y");
        check("p1011n_cnt", {24'd0, match_cnt}, 32'd1);

        // Enable gap holds history
        load_cfg(8'b0000_0111, 4'd3, 1'b0);
        step(1'b1, 1'b1, 1'b0, "en_y");
        step(1'b1, 1'b1, 1'b0, "en_y");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "en_off_y");
        step(1'b1, 1'b1, 1'b1, "en_y");
        check("en_cnt", {24'd0, match_cnt}, 32'd1);

        // Asynchronous reset mid-run
        load_cfg(8'b0000_0111, 4'd3, 1'b1);
        run_stream(32'b111, 32'b001, 3, "pre_rst_y");
        rst = 1'b0;
        #1;
        check("arst_y", {31'd0, y_out}, 32'd0);
        check("arst_cnt", {24'd0, match_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_stream(32'b111, 32'b000, 3, "post_rst_idle_y");
        load_cfg(8'b0000_0111, 4'd3, 1'b1);
        run_stream(32'b111, 32'b001, 3, "post_rst_y");

        // Invalid lengths
        load_cfg(8'b0000_0001, 4'd0, 1'b1);
        check("len0_err", {31'd0, cfg_err}, 32'd1);
        run_stream(32'b1111, 32'b0000, 4, "len0_y");
        check("len0_cnt", {24'd0, match_cnt}, 32'd0);
        load_cfg(8'b0000_0001, 4'd9, 1'b1);
        check("len9_err", {31'd0, cfg_err}, 32'd1);
        load_cfg(8'b0000_0001, 4'd8, 1'b1);
        check("len8_err", {31'd0, cfg_err}, 32'd0);

        // Mid-pattern reload clears history; upper pat bits are don't-care
        load_cfg(8'b1111_0101, 4'd3, 1'b0);
        run_stream(32'b10, 32'b00, 2, "mid_y");
        load_cfg(8'b1111_0101, 4'd3, 1'b0);
        run_stream(32'b101, 32'b001, 3, "mid_after_y");

        // Pattern "1" back-to-back; the 2-bit counter saturates at 3
        load_cfg(8'b0000_0001, 4'd1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1, 1'b1, "one_y");
            check("sat_y", {31'd0, y_sat}, 32'd1);
            check("sat_cnt", {30'd0, cnt_sat}, (i < 3) ? i : 32'd3);
            check("wide_cnt", {24'd0, match_cnt}, i);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
